// File: rtl/cpu_pkg.sv
// cpu_pkg
// Definitions shared by the pipeline front end.
//   fetch_state_t    : fetch sequencer states (FETCH, HOLD, DRAIN)
//   OPC_W            : width of the opcode field at the top of an instruction
//   DEFAULT_RESET_PC : address of the first fetch after reset
package cpu_pkg;

  localparam int OPC_W            = 3;
  localparam int DEFAULT_RESET_PC = 0;

  // FETCH : request outstanding at the program counter
  // HOLD  : output and skid both full, no request issued
  // DRAIN : a response for a redirected-away address is still owed by memory
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid
// One-entry skid buffer that catches an instruction returned by memory while
// the output register is stalled by the downstream stage.
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   i_flush       : discard the held entry (redirect)
//   i_load        : capture i_data / i_pc_next
//   i_pop         : entry has been moved to the output register
//   i_data        : instruction word to capture
//   i_pc_next     : address of that instruction + 1
//   o_valid       : entry is occupied
//   o_data        : held instruction word
//   o_pc_next     : held address + 1
module fetch_skid
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [PC_W-1:0]   i_pc_next,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [PC_W-1:0]   o_pc_next
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [PC_W-1:0]   r_pc_next;

  // Flush wins over load so a redirect never leaves a stale wrong-path entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_pc_next <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_data    <= i_data;
      r_pc_next <= i_pc_next;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_pc_next = r_pc_next;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch stage: issues word requests to instruction memory,
// presents fetched instructions to decode with a valid/ready handshake,
// absorbs one extra word in a skid buffer when decode stalls, and handles
// branch/jump redirects including responses still owed by memory.
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   imem_req         : request to instruction memory
//   imem_addr        : word address of the request
//   imem_ack         : response valid (only meaningful while imem_req=1)
//   imem_rdata       : instruction word returned with imem_ack
//   redirect_valid   : taken branch/jump this cycle
//   redirect_pc      : redirect target
//   if_ready         : decode accepts the presented instruction
//   if_valid         : if_instr / if_pc_next / operation are live
//   if_instr         : fetched instruction
//   if_pc_next       : address of the fetched instruction + 1
//   operation        : opcode field, zero while if_valid=0
//   perf_fetched     : handshake counter, saturating (only with FETCH_PERF_EN)
// Build option: define FETCH_PERF_EN to add the perf_fetched counter port.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               if_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc_next,
  output logic [OPC_W-1:0]   operation
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched
`endif
);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_drain_addr;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc_next;

  logic               w_pc_inc_valid;
  logic [PC_W-1:0]    w_pc_inc;
  logic               w_out_free;
  logic               w_skid_load;
  logic               w_skid_pop;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_data;
  logic [PC_W-1:0]    w_skid_pc_next;

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_out_free = !r_valid || if_ready;

  // The skid only fills when an accepted response finds the output stalled;
  // HOLD is entered on exactly that edge, so skid occupancy tracks HOLD.
  assign w_skid_load    = (r_state == FETCH) && !redirect_valid && imem_ack && !w_out_free;
  assign w_skid_pop     = (r_state == HOLD) && !redirect_valid && if_ready;
  assign w_pc_inc_valid = w_skid_valid;

  fetch_skid #(
    .DATA_W (INSTR_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (redirect_valid),
    .i_load    (w_skid_load),
    .i_pop     (w_skid_pop),
    .i_data    (imem_rdata),
    .i_pc_next (w_pc_inc),
    .o_valid   (w_skid_valid),
    .o_data    (w_skid_data),
    .o_pc_next (w_skid_pc_next)
  );

  // In DRAIN the request must keep pointing at the address memory is still
  // answering, while r_pc already holds the redirect target.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    case (r_state)
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = r_pc;
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = r_drain_addr;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
      end
    endcase
  end

  // Sequencer and output register. Redirect is checked first in every state;
  // reset outranks everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_pc_next    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (redirect_valid) begin
            r_valid <= 1'b0;
            r_pc    <= redirect_pc;
            // Without an ack this cycle memory still owes a response for the
            // old address; it must be swallowed before fetching the target.
            if (!imem_ack) begin
              r_state      <= DRAIN;
              r_drain_addr <= r_pc;
            end
          end else if (imem_ack) begin
            r_pc <= w_pc_inc;
            if (w_out_free) begin
              r_valid   <= 1'b1;
              r_instr   <= imem_rdata;
              r_pc_next <= w_pc_inc;
            end else begin
              r_state <= HOLD;
            end
          end else if (if_ready) begin
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_valid <= 1'b0;
            r_pc    <= redirect_pc;
            r_state <= FETCH;
          end else if (if_ready && w_pc_inc_valid) begin
            r_instr   <= w_skid_data;
            r_pc_next <= w_skid_pc_next;
            r_state   <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end
          if (imem_ack) begin
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign if_valid   = r_valid;
  assign if_instr   = r_instr;
  assign if_pc_next = r_pc_next;
  assign operation  = r_valid ? r_instr[INSTR_W-1 -: OPC_W] : '0;

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf;

  // Counts accepted instructions; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else if (r_valid && if_ready && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_fetched = r_perf;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Self-checking bench for fetch_stage: a directed vector table with
// hand-derived expectations, randomized traffic compared cycle by cycle
// against a queue-based model, and counter checks when FETCH_PERF_EN is set.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        if_ready = 1'b0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic [2:0]  operation;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
`endif

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_ready       (if_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc_next     (if_pc_next),
    .operation      (operation)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [15:0] rdata;
    logic        redir;
    logic [15:0] rpc;
    logic        ready;
    logic        chk;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expInstr;
    logic [15:0] expPcn;
    logic [2:0]  expOp;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcn;
  } item_t;

  int testsRun = 0;
  int failures = 0;

  // Reference model: instructions owed to decode as a FIFO of at most two
  // (output register plus skid), a fetch pointer and an owed-response flag.
  item_t       mQ[$];
  logic [15:0] mPc = '0;
  logic [15:0] mDrainAddr = '0;
  bit          mDraining = 0;
  bit          modelReady = 0;
  int          mPerf = 0;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic rst, logic ack, logic [15:0] rdata, logic redir,
                                 logic [15:0] rpc, logic ready, logic chk, logic eReq,
                                 logic [15:0] eAddr, logic eValid, logic [15:0] eInstr,
                                 logic [15:0] ePcn, logic [2:0] eOp);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc;
    v.ready = ready; v.chk = chk; v.expReq = eReq; v.expAddr = eAddr;
    v.expValid = eValid; v.expInstr = eInstr; v.expPcn = ePcn; v.expOp = eOp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic modelStep(input vec_t v);
    bit hand;
    bit fetching;
    item_t it;
    if (v.rst) begin
      mQ.delete();
      mDraining  = 0;
      mPc        = 16'h0000;
      mPerf      = 0;
      modelReady = 1;
      return;
    end
    hand     = (mQ.size() > 0) && v.ready;
    fetching = !mDraining && (mQ.size() < 2);
    if (hand && mPerf < 65535) mPerf++;
    if (v.redir) begin
      mQ.delete();
      if (mDraining) begin
        if (v.ack) mDraining = 0;
      end else if (fetching && !v.ack) begin
        mDraining  = 1;
        mDrainAddr = mPc;
      end
      mPc = v.rpc;
    end else if (mDraining) begin
      if (v.ack) mDraining = 0;
    end else begin
      if (hand) void'(mQ.pop_front());
      if (fetching && v.ack) begin
        it.instr = v.rdata;
        it.pcn   = 16'(mPc + 16'd1);
        mQ.push_back(it);
        mPc = it.pcn;
      end
    end
  endtask

  // Check outputs of the current cycle (model and, if requested, the table
  // row), then drive the row's inputs across the next rising edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    bit          eReq;
    bit          eValid;
    logic [15:0] eAddr;
    logic [2:0]  eOp;
    @(negedge clk);
    if (modelReady) begin
      eReq   = mDraining || (mQ.size() < 2);
      eAddr  = mDraining ? mDrainAddr : mPc;
      eValid = mQ.size() > 0;
      eOp    = eValid ? mQ[0].instr[15:13] : 3'b000;
      checkOutput({tag, ".model.req"}, 32'(imem_req), 32'(eReq));
      if (eReq) checkOutput({tag, ".model.addr"}, 32'(imem_addr), 32'(eAddr));
      checkOutput({tag, ".model.valid"}, 32'(if_valid), 32'(eValid));
      if (eValid) begin
        checkOutput({tag, ".model.instr"}, 32'(if_instr), 32'(mQ[0].instr));
        checkOutput({tag, ".model.pcNext"}, 32'(if_pc_next), 32'(mQ[0].pcn));
      end
      checkOutput({tag, ".model.op"}, 32'(operation), 32'(eOp));
`ifdef FETCH_PERF_EN
      checkOutput({tag, ".model.perf"}, 32'(perf_fetched), 32'(mPerf));
`endif
    end
    if (v.chk) begin
      checkOutput({tag, ".req"}, 32'(imem_req), 32'(v.expReq));
      if (v.expReq) checkOutput({tag, ".addr"}, 32'(imem_addr), 32'(v.expAddr));
      checkOutput({tag, ".valid"}, 32'(if_valid), 32'(v.expValid));
      if (v.expValid) begin
        checkOutput({tag, ".instr"}, 32'(if_instr), 32'(v.expInstr));
        checkOutput({tag, ".pcNext"}, 32'(if_pc_next), 32'(v.expPcn));
      end
      checkOutput({tag, ".op"}, 32'(operation), 32'(v.expOp));
    end
    reset          = v.rst;
    imem_ack       = v.ack;
    imem_rdata     = v.rdata;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    if_ready       = v.ready;
    @(posedge clk);
    modelStep(v);
  endtask

  initial begin
    vec_t v;

    // rst ack rdata redir rpc ready | chk req addr valid instr pcn op
    // Streaming from reset, one instruction per cycle.
    vecs.push_back(mkVec(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 1, 16'h2111, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 1, 16'h4222, 0, 16'h0000, 1, 1, 1, 16'h0001, 1, 16'h2111, 16'h0001, 3'd1));
    vecs.push_back(mkVec(0, 1, 16'h6333, 0, 16'h0000, 1, 1, 1, 16'h0002, 1, 16'h4222, 16'h0002, 3'd2));
    vecs.push_back(mkVec(0, 1, 16'hE444, 0, 16'h0000, 1, 1, 1, 16'h0003, 1, 16'h6333, 16'h0003, 3'd3));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0004, 1, 16'hE444, 16'h0004, 3'd7));
    // Stall with A123 presented, B456 lands in the skid, HOLD drops the request.
    vecs.push_back(mkVec(0, 1, 16'hA123, 0, 16'h0000, 0, 1, 1, 16'h0004, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 1, 16'hB456, 0, 16'h0000, 0, 1, 1, 16'h0005, 1, 16'hA123, 16'h0005, 3'd5));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'hA123, 16'h0005, 3'd5));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'hA123, 16'h0005, 3'd5));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'hA123, 16'h0005, 3'd5));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0006, 1, 16'hB456, 16'h0006, 3'd5));
    // Redirect to 5 with same-cycle ack, then redirect to 0x40 with request pending.
    vecs.push_back(mkVec(0, 1, 16'hFFFF, 1, 16'h0005, 1, 1, 1, 16'h0006, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 0, 16'h0000, 1, 16'h0040, 1, 1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 1, 16'hFFFF, 0, 16'h0000, 1, 1, 1, 16'h0005, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 1, 16'h2001, 0, 16'h0000, 1, 1, 1, 16'h0040, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0041, 1, 16'h2001, 16'h0041, 3'd1));
    // Wrap at the top of the address space.
    vecs.push_back(mkVec(0, 1, 16'h1234, 1, 16'hFFFF, 1, 1, 1, 16'h0041, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 1, 16'h4000, 0, 16'h0000, 1, 1, 1, 16'hFFFF, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0000, 1, 16'h4000, 16'h0000, 3'd2));
    // Reset while draining abandons the owed response.
    vecs.push_back(mkVec(0, 1, 16'h5555, 1, 16'h0077, 1, 1, 1, 16'h0000, 1, 16'h4000, 16'h0000, 3'd2));
    vecs.push_back(mkVec(0, 0, 16'h0000, 1, 16'h0030, 1, 1, 1, 16'h0077, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(1, 1, 16'h9999, 1, 16'h0055, 1, 1, 1, 16'h0077, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));
    vecs.push_back(mkVec(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      v.rst   = ($urandom_range(0, 199) == 0);
      v.ack   = ($urandom_range(0, 99) < 65);
      v.rdata = 16'($urandom);
      v.redir = ($urandom_range(0, 9) == 0);
      v.rpc   = 16'($urandom);
      v.ready = ($urandom_range(0, 99) < 60);
      v.chk   = 0;
      v.expReq = 0; v.expAddr = '0; v.expValid = 0;
      v.expInstr = '0; v.expPcn = '0; v.expOp = '0;
      applyStimulus(v, $sformatf("rnd%0d", i));
    end

`ifdef FETCH_PERF_EN
    // Five handshakes after reset, then run the counter into saturation.
    v = mkVec(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0);
    applyStimulus(v, "perfRst");
    for (int i = 0; i < 6; i++) begin
      v = mkVec(0, 1, 16'(i), 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0);
      applyStimulus(v, $sformatf("perf%0d", i));
    end
    v = mkVec(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0);
    applyStimulus(v, "perfIdle");
    @(negedge clk);
    checkOutput("perf.five", 32'(perf_fetched), 32'd5);
    for (int i = 0; i < 65540; i++) begin
      v = mkVec(0, 1, 16'h1000, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0);
      applyStimulus(v, "perfSat");
    end
    @(negedge clk);
    checkOutput("perf.saturated", 32'(perf_fetched), 32'h0000FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 16, PC width in words.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width; opcode is bits [INSTR_W-1:INSTR_W-3].
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port imem_req  output  1  instruction-memory request.
REQ-007 SHALL have port imem_addr  output  PC_W  word address of request.
REQ-008 SHALL have port imem_ack  input  1  response valid; sampled only while imem_req=1.
REQ-009 SHALL have port imem_rdata  input  INSTR_W  instruction, valid with imem_ack.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-011 SHALL have port redirect_pc  input  PC_W  target address.
REQ-012 SHALL have port if_ready  input  1  decode/control stage accepts instruction.
REQ-013 SHALL have port if_valid  output  1  if_instr/if_pc_next/operation hold a live instruction.
REQ-014 SHALL have port if_instr  output  INSTR_W  fetched instruction.
REQ-015 SHALL have port if_pc_next  output  PC_W  address of fetched instruction + 1.
REQ-016 SHALL have port operation  output  3  opcode field for the control unit; 3'b000 when if_valid=0.

Function
REQ-017 SHALL implement states FETCH, HOLD, DRAIN.
REQ-018 FETCH: imem_req=1, imem_addr=pc; imem_req/imem_addr SHALL stay stable until imem_ack.
REQ-019 FETCH, ack, output empty or if_ready=1: load output register next edge, if_valid=1, pc<=pc+1 (wraps modulo 2^PC_W), stay FETCH; zero-bubble throughput of 1 instr/cycle with same-cycle ack.
REQ-020 FETCH, ack, if_valid=1 and if_ready=0: store in one-entry skid buffer, pc<=pc+1, go HOLD.
REQ-021 HOLD: imem_req=0; on if_ready=1 skid moves to output register, go FETCH.
REQ-022 Output handshake: if_instr/if_pc_next/if_valid SHALL hold unchanged while if_valid=1 and if_ready=0.
REQ-023 redirect_valid SHALL have highest priority: next edge if_valid<=0, skid cleared, pc<=redirect_pc.
REQ-024 Redirect in FETCH without same-cycle ack: go DRAIN; DRAIN keeps imem_req=1 at old address, discards response on ack, then goes FETCH at new pc.
REQ-025 Redirect with same-cycle ack, or in HOLD: response/skid discarded, go FETCH directly.
REQ-026 Redirect during DRAIN SHALL update pc only; DRAIN continues.
REQ-027 Latency: ack at edge N -> if_valid=1 after edge N+1 when output free.

Reset
REQ-028 While reset=1 at an edge: state<=FETCH, pc<=RESET_PC, if_valid<=0, skid empty, if_instr<=0, if_pc_next<=0; reset overrides redirect and ack.
REQ-029 First cycle after reset SHALL present imem_req=1, imem_addr=RESET_PC; reset mid-DRAIN SHALL abandon the outstanding response without waiting.

Configuration
REQ-030 With FETCH_PERF_EN defined: output perf_fetched [15:0], count of if_valid&&if_ready handshakes, saturating at 16'hFFFF, cleared by reset.
REQ-031 Without FETCH_PERF_EN: port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared package cpu_pkg SHALL hold fetch_state_t enum (FETCH, HOLD, DRAIN), opcode field width constant OPC_W=3, and default reset PC constant.
REQ-033 Skid buffer SHALL be sub-module fetch_skid (one entry: data, pc_next, valid, flush).

Verification
REQ-034 Reset, ack every cycle, if_ready=1 -> imem_addr 0,1,2,3 consecutive cycles; if_pc_next 1,2,3,4; no bubbles.
REQ-035 if_instr=16'hA123 held, if_ready=0 for 3 cycles -> if_valid, if_instr stable; second word captured in skid; imem_req=0 in HOLD; both delivered in order on if_ready=1.
REQ-036 Redirect to 16'h0040 while request to 16'h0005 pending, ack 2 cycles later -> that response discarded, next imem_addr=16'h0040, operation=3'b000 meanwhile.
REQ-037 pc=16'hFFFF ack -> if_pc_next=16'h0000, next imem_addr=16'h0000.
REQ-038 Reset asserted in DRAIN -> next cycle imem_addr=RESET_PC, if_valid=0; late ack ignored.
REQ-039 FETCH_PERF_EN build, 5 handshakes -> perf_fetched=5; counter held at 16'hFFFF after saturation.
